truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 100 ++++++++++
 tb/tb_truth_table_sweeper.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all eight 3-bit input vectors into a combinational gate and captures its truth table
// Ports: clk, rst_n (async active-low); start/abort control; expected (bit 7-k = output for vector k);
//        settle (extra wait cycles per vector); dut_in/dut_out connect to the gate under test;
//        busy, done (one-cycle pulse), pass, measured report the sweep result.
// Option: define MISMATCH_LOG_EN to add fail_seen/first_fail, recording the first mismatching vector.
module truth_table_sweeper #(
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          expected,
  input  logic [SETTLE_W-1:0] settle,
  output logic [2:0]          dut_in,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          measured
`ifdef MISMATCH_LOG_EN
  ,
  output logic                fail_seen,
  output logic [2:0]          first_fail
`endif
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t              r_state, w_state_nxt;
  logic [7:0]          r_exp, r_meas, w_meas_nxt;
  logic [SETTLE_W-1:0] r_settle, r_cnt;
  logic [2:0]          r_idx;
  logic                r_pass;
  logic                w_start, w_abort, w_cap;
  always_comb begin
    w_start     = r_state == IDLE && start && !abort;
    w_abort     = r_state == SETTLE && abort;
    w_cap       = r_state == SETTLE && !abort && r_cnt == '0;
    w_meas_nxt  = r_meas;
    w_meas_nxt[3'd7 - r_idx] = dut_out;
    w_state_nxt = w_start                  ? SETTLE :
                  r_state == DONE          ? IDLE   :
                  w_abort                  ? IDLE   :
                  (w_cap && r_idx == 3'd7) ? DONE   : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_exp    <= '0;
      r_settle <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_meas   <= '0;
      r_pass   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_exp    <= expected;
        r_settle <= settle;
        r_idx    <= '0;
        r_cnt    <= settle;
        r_meas   <= '0;
        r_pass   <= 1'b0;
      end else if (w_abort) begin
        // partial capture stays visible in measured
        r_idx <= '0;
        r_cnt <= '0;
      end else if (w_cap) begin
        r_meas <= w_meas_nxt;
        if (r_idx == 3'd7) r_pass <= w_meas_nxt == r_exp;
        else begin
          r_idx <= r_idx + 3'd1;
          r_cnt <= r_settle;
        end
      end else if (r_state == SETTLE) r_cnt <= r_cnt - SETTLE_W'(1);
    end
  end
`ifdef MISMATCH_LOG_EN
  logic       r_fail_seen;
  logic [2:0] r_first_fail;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_seen  <= 1'b0;
      r_first_fail <= '0;
    end else if (w_start) begin
      r_fail_seen  <= 1'b0;
      r_first_fail <= '0;
    end else if (w_cap && !r_fail_seen && dut_out != r_exp[3'd7 - r_idx]) begin
      r_fail_seen  <= 1'b1;
      r_first_fail <= r_idx;
    end
  end
  assign fail_seen  = r_fail_seen;
  assign first_fail = r_first_fail;
`endif
  assign dut_in   = r_state == SETTLE ? r_idx : 3'd0;
  assign busy     = r_state == SETTLE;
  assign done     = r_state == DONE;
  assign pass     = r_pass;
  assign measured = r_meas;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: table-driven, scoreboarded bench for truth_table_sweeper
module tb_truth_table_sweeper;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = '0;
  logic [3:0] settle = '0;
  logic [2:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass;
  logic [7:0] measured;
  logic [7:0] gate = 8'h64;
`ifdef MISMATCH_LOG_EN
  logic       fail_seen;
  logic [2:0] first_fail;
`endif
  int checks = 0;
  int errors = 0;

  truth_table_sweeper #(.SETTLE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .settle(settle), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .measured(measured)
`ifdef MISMATCH_LOG_EN
    , .fail_seen(fail_seen), .first_fail(first_fail)
`endif
  );

  always #5 clk = ~clk;
  // model gate: output for vector k is gate[7-k]
  assign dut_out = gate[3'd7 - dut_in];

  typedef struct {
    logic [7:0] g;
    logic [7:0] e;
    logic [3:0] s;
  } vec_t;
  typedef struct {
    logic [7:0] meas;
    logic       pass;
    int         cyc;
    logic       fs;
    logic [2:0] ff;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic check_idle_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_pass"}, pass, 0);
    chk({nm, "_measured"}, measured, 0);
    chk({nm, "_dut_in"}, dut_in, 0);
`ifdef MISMATCH_LOG_EN
    chk({nm, "_fail_seen"}, fail_seen, 0);
`endif
  endtask

  // one sweep; restart=1 pulses start mid-sweep with different expected/settle
  task automatic sweep(input vec_t v, input bit restart);
    exp_t x, got;
    int n, bad;
    x.meas = v.g;
    x.pass = v.g == v.e;
    x.cyc  = 8 * (int'(v.s) + 1) + 1;
    x.fs   = v.g != v.e;
    x.ff   = '0;
    for (int k = 7; k >= 0; k--) if (v.g[7-k] != v.e[7-k]) x.ff = 3'(k);
    @(negedge clk);
    gate = v.g; expected = v.e; settle = v.s; start = 1'b1;
    sb.push_back(x);
    n = 0; bad = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      start = restart && n == 3;
      if (start) begin expected = ~v.e; settle = v.s + 4'd1; end
      if (done) break;
      if (dut_in !== 3'((n - 1) / (int'(v.s) + 1)) || !busy) bad++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("dut_in_seq", bad, 0);
    got.cyc = n;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("done_cycle", got.cyc, x.cyc);
      chk("measured", measured, x.meas);
      chk("pass", pass, x.pass);
      chk("busy_at_done", busy, 0);
`ifdef MISMATCH_LOG_EN
      chk("fail_seen", fail_seen, x.fs);
      if (x.fs) chk("first_fail", first_fail, x.ff);
`endif
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("dut_in_idle", dut_in, 0);
    chk("pass_hold", pass, x.pass);
  endtask

  initial begin
    vec_t tbl[6];
    tbl[0] = '{8'h64, 8'h64, 4'd0};
    tbl[1] = '{8'h64, 8'h64, 4'd3};
    tbl[2] = '{8'h64, 8'h66, 4'd1};
    tbl[3] = '{8'h00, 8'hFF, 4'd0};
    tbl[4] = '{8'hFF, 8'hFF, 4'd15};
    tbl[5] = '{8'hA5, 8'h5A, 4'd2};
    #12;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("after_reset");
    for (int i = 0; i < 6; i++) sweep(tbl[i], 1'b0);
    // start ignored mid-sweep; original expected and settle stay in force
    sweep('{8'h64, 8'h64, 4'd2}, 1'b1);
    // abort has priority over start in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_done", done, 0);
    // abort during vector 3 (settle=2: vector 3 covers cycles 10..12)
    @(negedge clk);
    gate = 8'h64; expected = 8'h64; settle = 4'd2; start = 1'b1;
    repeat (10) @(negedge clk) start = 1'b0;
    chk("abort_vec3", dut_in, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_dut_in", dut_in, 0);
    chk("abort_pass", pass, 0);
    chk("abort_measured", measured, 8'h60);
    begin
      int seen = 0;
      repeat (30) begin @(negedge clk); if (done || busy) seen++; end
      chk("abort_no_done", seen, 0);
    end
    // async reset mid-sweep, no clock edge in between
    @(negedge clk);
    gate = 8'hC3; expected = 8'hC3; settle = 4'd1; start = 1'b1;
    repeat (9) @(negedge clk) start = 1'b0;
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_idle_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    sweep('{8'hC3, 8'hC3, 4'd1}, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
